// File: rtl/asi_pkg.sv
// Shared types for the AXI-to-single-port-RAM arbiter slice.
// The arbiter state lives here so other ASI blocks can decode it.
package asi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_t;

  localparam int HOLD_CNT_W = 9;

endpackage

// File: rtl/asi_ws_pipe.sv
// Read-data-valid delay line: carries valid/last from the registered RAM read
// command to the cycle the RAM presents rdata, SLV_WS cycles later.
module asi_ws_pipe #(
  parameter int SLV_WS = 2
) (
  input  logic usr_clk,
  input  logic usr_reset_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  generate
    if (SLV_WS == 0) begin : g_comb
      // Zero wait states: rdata is valid in the same cycle as the command.
      logic unused_clk_rst;
      assign unused_clk_rst = usr_clk ^ usr_reset_n;
      assign out_valid      = in_valid;
      assign out_last       = in_last;
    end else begin : g_pipe
      logic [SLV_WS-1:0] v_sr;
      logic [SLV_WS-1:0] l_sr;

      always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
          v_sr <= '0;
          l_sr <= '0;
        end else begin
          v_sr[0] <= in_valid;
          l_sr[0] <= in_last;
          for (int i = 1; i < SLV_WS; i++) begin
            v_sr[i] <= v_sr[i-1];
            l_sr[i] <= l_sr[i-1];
          end
        end
      end

      assign out_valid = v_sr[SLV_WS-1];
      assign out_last  = l_sr[SLV_WS-1];
    end
  endgenerate

endmodule

// File: rtl/asi_spram_arb.sv
// Arbitrates AXI write and read beats onto one single-port RAM, with a
// bounded hold time so neither side can starve the other.
module asi_spram_arb
  import asi_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SLV_WS   = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic            usr_clk,
  input  logic            usr_reset_n,
  input  logic            w_req,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_strb,
  input  logic            w_last,
  output logic            w_gnt,
  input  logic            r_req,
  input  logic [AW-1:0]   r_addr,
  input  logic            r_last,
  output logic            r_gnt,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_be,
  output logic            r_valid,
  output logic            r_vlast,
  output logic            w_busy,
  output logic            r_busy
);

  localparam int HOLD_LIM = MAX_HOLD - 1;

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic                  last_wr;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  hold_up;
  logic                  rd_last_q;
  logic                  rd_cmd;

  // The beat being granted now brings the owner's tenure to its limit.
  assign hold_up = (int'(hold_cnt) + 1) >= HOLD_LIM;

  // Grants are held off during reset so no beat is accepted that the
  // cleared RAM registers would then silently drop.
  always_comb begin
    w_gnt     = 1'b0;
    r_gnt     = 1'b0;
    state_nxt = state;
    if (usr_reset_n) begin
      unique case (state)
        IDLE: begin
          if (w_req && (!r_req || !last_wr)) begin
            w_gnt     = 1'b1;
            state_nxt = WR;
          end else if (r_req) begin
            r_gnt     = 1'b1;
            state_nxt = RD;
          end
        end
        WR: begin
          if (w_req) begin
            w_gnt = 1'b1;
            if (w_last)
              state_nxt = r_req ? RD : IDLE;
            else if (r_req && hold_up)
              state_nxt = RD;
          end else if (r_req) begin
            r_gnt     = 1'b1;
            state_nxt = RD;
          end
        end
        RD: begin
          if (r_req) begin
            r_gnt = 1'b1;
            if (r_last)
              state_nxt = w_req ? WR : IDLE;
            else if (w_req && hold_up)
              state_nxt = WR;
          end else if (w_req) begin
            w_gnt     = 1'b1;
            state_nxt = WR;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state    <= IDLE;
      last_wr  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (w_gnt)
        last_wr <= 1'b1;
      else if (r_gnt)
        last_wr <= 1'b0;
      if (state_nxt != state)
        hold_cnt <= '0;
      else if ((w_gnt || r_gnt) && (hold_cnt != '1))
        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
    end
  end

  // Write data is left untouched by reads so the RAM data bus stays quiet.
  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
      rd_last_q <= 1'b0;
    end else begin
      ram_cs    <= w_gnt | r_gnt;
      ram_we    <= w_gnt;
      rd_last_q <= r_gnt & r_last;
      if (w_gnt) begin
        ram_addr  <= w_addr;
        ram_wdata <= w_data;
        ram_be    <= w_strb;
      end else if (r_gnt) begin
        ram_addr <= r_addr;
        ram_be   <= '0;
      end
    end
  end

  assign rd_cmd = ram_cs & ~ram_we;

  asi_ws_pipe #(
    .SLV_WS(SLV_WS)
  ) u_ws_pipe (
    .usr_clk    (usr_clk),
    .usr_reset_n(usr_reset_n),
    .in_valid   (rd_cmd),
    .in_last    (rd_last_q),
    .out_valid  (r_valid),
    .out_last   (r_vlast)
  );

  assign w_busy = (state == WR);
  assign r_busy = (state == RD);

endmodule

// File: tb/tb_asi_spram_arb.sv
// Bench for asi_spram_arb: directed vector table, hold/preempt and reset
// sequences, then random traffic against a side-symmetric reference model.
module tb_asi_spram_arb;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int SLV_WS   = 2;
  localparam int MAX_HOLD = 4;

  logic            usr_clk = 1'b0;
  logic            usr_reset_n;
  logic            w_req, w_last, r_req, r_last;
  logic [AW-1:0]   w_addr, r_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_gnt, r_gnt, ram_cs, ram_we, r_valid, r_vlast, w_busy, r_busy;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW/8-1:0] ram_be;

  always #5 usr_clk = ~usr_clk;

  asi_spram_arb #(
    .AW(AW), .DW(DW), .SLV_WS(SLV_WS), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
    .w_last(w_last), .w_gnt(w_gnt),
    .r_req(r_req), .r_addr(r_addr), .r_last(r_last), .r_gnt(r_gnt),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be),
    .r_valid(r_valid), .r_vlast(r_vlast), .w_busy(w_busy), .r_busy(r_busy)
  );

  typedef struct {
    logic [4:0] ctl;    // {reset_n, w_req, w_last, r_req, r_last}
    logic [7:0] wa;
    logic [7:0] ra;
    logic [3:0] xg;     // {w_gnt, r_gnt, ram_cs, ram_we}
    logic [7:0] xaddr;
    logic [3:0] xo;     // {r_valid, r_vlast, w_busy, r_busy}
  } vec_t;

  typedef struct {
    int due;
    bit last;
  } rd_t;

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  bit  got_w, got_r;

  // Reference model: owner -1 = nobody, 0 = write side, 1 = read side.
  int              m_owner;
  bit              m_last_w;
  int              m_tenure;
  bit              e_cs, e_we;
  logic [AW-1:0]   e_addr;
  logic [DW-1:0]   e_wdata;
  logic [DW/8-1:0] e_be;
  rd_t             rdq[$];

  function automatic logic [75:0] obs();
    return {w_gnt, r_gnt, ram_cs, ram_we, ram_addr, ram_wdata, ram_be,
            r_valid, r_vlast, w_busy, r_busy};
  endfunction

  task automatic checkOutput(input string name, input logic [75:0] got, input logic [75:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    m_owner  = -1;
    m_last_w = 1'b0;
    m_tenure = 0;
    e_cs     = 1'b0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_wdata  = '0;
    e_be     = '0;
    rdq.delete();
  endtask

  // Pick this cycle's grant from the current owner and requests.
  task automatic modelDecide(output bit gw, output bit gr, output int nxt);
    bit req[2];
    bit lst[2];
    bit g[2];
    int s, o;
    req[0] = w_req;  req[1] = r_req;
    lst[0] = w_last; lst[1] = r_last;
    g[0] = 1'b0;     g[1] = 1'b0;
    nxt = m_owner;
    if (usr_reset_n !== 1'b1) begin
      nxt = -1;
    end else if (m_owner < 0) begin
      if (req[0] && req[1]) s = m_last_w ? 1 : 0;
      else if (req[0])      s = 0;
      else if (req[1])      s = 1;
      else                  s = -1;
      if (s >= 0) begin
        g[s] = 1'b1;
        nxt  = s;
      end
    end else begin
      s = m_owner;
      o = 1 - s;
      if (req[s]) begin
        g[s] = 1'b1;
        if (lst[s])                                    nxt = req[o] ? o : -1;
        else if (req[o] && (m_tenure + 1 >= MAX_HOLD - 1)) nxt = o;
      end else if (req[o]) begin
        g[o] = 1'b1;
        nxt  = o;
      end
    end
    gw = g[0];
    gr = g[1];
  endtask

  // Samples one cycle (inputs already driven at the negedge), compares
  // against the model, then advances the model across the coming edge.
  task automatic applyStimulus();
    bit gw, gr, ev, evl;
    int nxt;
    #1;
    modelDecide(gw, gr, nxt);
    ev  = (rdq.size() > 0) && (rdq[0].due == cyc);
    evl = ev && rdq[0].last;
    checkOutput("model", obs(),
                {gw, gr, e_cs, e_we, e_addr, e_wdata, e_be, ev, evl,
                 m_owner == 0, m_owner == 1});
    got_w = w_gnt;
    got_r = r_gnt;
    if (ev) void'(rdq.pop_front());
    if (usr_reset_n !== 1'b1) begin
      modelReset();
    end else begin
      m_tenure = (nxt == m_owner) ? m_tenure + int'(gw | gr) : 0;
      m_owner  = nxt;
      if (gw) m_last_w = 1'b1;
      else if (gr) m_last_w = 1'b0;
      e_cs = gw | gr;
      e_we = gw;
      if (gw) begin
        e_addr  = w_addr;
        e_wdata = w_data;
        e_be    = w_strb;
      end else if (gr) begin
        e_addr = r_addr;
        e_be   = '0;
        rdq.push_back('{due: cyc + 1 + SLV_WS, last: r_last});
      end
    end
    cyc++;
  endtask

  task automatic idleInputs();
    usr_reset_n = 1'b1;
    w_req = 1'b0; w_last = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
    r_req = 1'b0; r_last = 1'b0; r_addr = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  tbl[$];
    string ord;
    int    rb, wb, lc;

    idleInputs();
    usr_reset_n = 1'b0;
    repeat (2) @(posedge usr_clk);
    @(negedge usr_clk);
    modelReset();

    // Reset with both requesting, write-first tie, 4-beat write, alternating
    // single beats, and a 3-beat read observed through the wait states.
    tbl.push_back('{5'b01010, 8'h00, 8'h40, 4'b0000, 8'h00, 4'b0000});
    tbl.push_back('{5'b11011, 8'h00, 8'h40, 4'b1000, 8'h00, 4'b0000});
    tbl.push_back('{5'b11111, 8'h04, 8'h40, 4'b1011, 8'h00, 4'b0010});
    tbl.push_back('{5'b10011, 8'h00, 8'h40, 4'b0111, 8'h04, 4'b0001});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0010, 8'h40, 4'b0000});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h40, 4'b0000});
    tbl.push_back('{5'b11000, 8'h00, 8'h00, 4'b1000, 8'h40, 4'b1100});
    tbl.push_back('{5'b11000, 8'h04, 8'h00, 4'b1011, 8'h00, 4'b0010});
    tbl.push_back('{5'b11000, 8'h08, 8'h00, 4'b1011, 8'h04, 4'b0010});
    tbl.push_back('{5'b11100, 8'h0C, 8'h00, 4'b1011, 8'h08, 4'b0010});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0011, 8'h0C, 4'b0000});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h0C, 4'b0000});
    tbl.push_back('{5'b11100, 8'h10, 8'h00, 4'b1000, 8'h0C, 4'b0000});
    tbl.push_back('{5'b10011, 8'h00, 8'h50, 4'b0111, 8'h10, 4'b0010});
    tbl.push_back('{5'b11100, 8'h14, 8'h00, 4'b1010, 8'h50, 4'b0001});
    tbl.push_back('{5'b10011, 8'h00, 8'h54, 4'b0111, 8'h14, 4'b0010});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0010, 8'h54, 4'b1101});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h54, 4'b0001});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h54, 4'b1101});
    tbl.push_back('{5'b10010, 8'h00, 8'h80, 4'b0100, 8'h54, 4'b0001});
    tbl.push_back('{5'b10010, 8'h00, 8'h84, 4'b0110, 8'h80, 4'b0001});
    tbl.push_back('{5'b10011, 8'h00, 8'h88, 4'b0110, 8'h84, 4'b0001});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0010, 8'h88, 4'b1000});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h88, 4'b1000});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h88, 4'b1100});
    tbl.push_back('{5'b10000, 8'h00, 8'h00, 4'b0000, 8'h88, 4'b0000});

    foreach (tbl[i]) begin
      usr_reset_n = tbl[i].ctl[4];
      w_req  = tbl[i].ctl[3];
      w_last = tbl[i].ctl[2];
      r_req  = tbl[i].ctl[1];
      r_last = tbl[i].ctl[0];
      w_addr = {24'h0, tbl[i].wa};
      w_data = {24'hDA7A00, tbl[i].wa};
      w_strb = 4'hF;
      r_addr = {24'h0, tbl[i].ra};
      applyStimulus();
      checkOutput($sformatf("row%0d", i),
                  {60'h0, w_gnt, r_gnt, ram_cs, ram_we, ram_addr[7:0],
                   r_valid, r_vlast, w_busy, r_busy},
                  {60'h0, tbl[i].xg, tbl[i].xaddr, tbl[i].xo});
      @(negedge usr_clk);
    end

    // 10-beat read with a 2-beat write arriving one cycle later: the read
    // yields after 4 beats and picks up again at beat 5.
    idleInputs();
    ord = "";
    rb  = 0;
    wb  = 0;
    lc  = 0;
    while ((rb < 10 || wb < 2) && lc < 40) begin
      r_req  = (rb < 10);
      r_addr = 32'h100 + 32'(4 * rb);
      r_last = (rb == 9);
      w_req  = (lc >= 1) && (wb < 2);
      w_addr = 32'h200 + 32'(4 * wb);
      w_data = $urandom;
      w_strb = 4'hF;
      w_last = (wb == 1);
      applyStimulus();
      if (got_w) begin wb++; ord = {ord, "W"}; end
      if (got_r) begin rb++; ord = {ord, "R"}; end
      lc++;
      @(negedge usr_clk);
    end
    n_vec++;
    if (ord != "RRRRWWRRRRRR") begin
      n_bad++;
      $display("[TB] FAIL hold_preempt: got order %s expected RRRRWWRRRRRR", ord);
    end
    idleInputs();
    repeat (6) begin
      applyStimulus();
      @(negedge usr_clk);
    end

    // Reset lands on the third of 8 read beats: nothing already issued may
    // come back as r_valid.
    for (int b = 0; b < 3; b++) begin
      r_req  = 1'b1;
      r_addr = 32'h300 + 32'(4 * b);
      r_last = 1'b0;
      usr_reset_n = (b != 2);
      applyStimulus();
      @(negedge usr_clk);
    end
    idleInputs();
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      if (k == 0) checkOutput("reset_all_zero", obs(), 76'h0);
      checkOutput($sformatf("no_valid_after_reset%0d", k), {75'h0, r_valid}, 76'h0);
      @(negedge usr_clk);
    end

    // Random traffic, including occasional resets, against the model.
    for (int n = 0; n < 600; n++) begin
      usr_reset_n = ($urandom_range(0, 63) != 0);
      w_req  = ($urandom_range(0, 3) != 0);
      w_last = ($urandom_range(0, 3) == 0);
      w_addr = $urandom;
      w_data = $urandom;
      w_strb = 4'($urandom);
      r_req  = ($urandom_range(0, 3) != 0);
      r_last = ($urandom_range(0, 3) == 0);
      r_addr = $urandom;
      applyStimulus();
      @(negedge usr_clk);
    end
    idleInputs();
    repeat (SLV_WS + 3) begin
      applyStimulus();
      @(negedge usr_clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
